// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   hz_state_e     : controller FSM state (RUN, MEM_WAIT)
//   HZ_REG_ADDR_W  : default register-specifier width of the MIPS core
package hazard_pkg;

    localparam int HZ_REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Performance counters for the hazard controller.
// Ports:
//   clk             in   core clock
//   rst             in   synchronous active-high reset, clears both counters
//   i_stall         in   this cycle is a stall (freeze or load-use bubble)
//   i_flush         in   IF/ID is flushed this cycle
//   o_stall_cycles  out  running count of stalled cycles (wraps)
//   o_flush_count   out  running count of IF/ID flushes (wraps)
module hazard_perf_cnt #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic [PERF_CNT_W-1:0] o_stall_cycles,
    output logic [PERF_CNT_W-1:0] o_flush_count
);

    logic [PERF_CNT_W-1:0] r_stall_cycles;
    logic [PERF_CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_stall) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (i_flush) r_flush_count  <= r_flush_count + 1'b1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Handles the
// hazards the forwarding network cannot: load-use (one-cycle ID/EX bubble),
// taken branch (IF/ID flush) and multi-cycle data memory (whole-pipeline
// freeze with a sticky timeout flag).
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IDEX_memread/IDEX_reg_rt load in EX and its destination
//   IFID_reg_rs/IFID_reg_rt  source specifiers of the instruction in ID
//   EXMEM_memread/_memwrite  MEM-stage load/store
//   dmem_ready               data memory completes this cycle
//   branch_taken             ID resolved a taken branch/jump
//   pc_write, IFID_write     PC and IF/ID enables
//   IFID_flush               IF/ID cleared to NOP
//   IDEX_bubble              ID/EX control bits zeroed
//   pipe_freeze              hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout              sticky memory-wait timeout flag
//   stall_cycles/flush_count perf counters (HAZARD_PERF_CNT_EN only)
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = HZ_REG_ADDR_W,
    parameter int MAX_MEM_WAIT = 16,
    parameter int PERF_CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IDEX_memread,
    input  logic [REG_ADDR_W-1:0] IDEX_reg_rt,
    input  logic [REG_ADDR_W-1:0] IFID_reg_rs,
    input  logic [REG_ADDR_W-1:0] IFID_reg_rt,
    input  logic                  EXMEM_memread,
    input  logic                  EXMEM_memwrite,
    input  logic                  dmem_ready,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  IFID_write,
    output logic                  IFID_flush,
    output logic                  IDEX_bubble,
    output logic                  pipe_freeze,
    output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
`endif
);

    localparam int WCNT_W = $clog2(MAX_MEM_WAIT + 1);

    hz_state_e         r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_timeout;

    logic w_mem_acc;
    logic w_lu;
    logic w_freeze;
    logic w_timeout_set;

    assign w_mem_acc = EXMEM_memread | EXMEM_memwrite;

    // $zero is never a real dependency, so a load targeting r0 never stalls.
    assign w_lu = IDEX_memread & (IDEX_reg_rt != '0) &
                  ((IDEX_reg_rt == IFID_reg_rs) | (IDEX_reg_rt == IFID_reg_rt));

    // A ready memory in the first cycle of an access costs nothing.
    assign w_freeze = ~dmem_ready &
                      (((r_state == RUN) & w_mem_acc) | (r_state == MEM_WAIT));

    // wait_cnt is about to reach MAX_MEM_WAIT (or already sits there) while
    // the memory is still busy; the flag is visible in that same cycle.
    assign w_timeout_set = (r_state == MEM_WAIT) & ~dmem_ready &
                           (r_wait_cnt >= WCNT_W'(MAX_MEM_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_acc && !dmem_ready) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        r_state <= RUN;
                    end else begin
                        if (r_wait_cnt < WCNT_W'(MAX_MEM_WAIT))
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (w_timeout_set)
                            r_timeout <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Priority: reset > freeze > load-use > flush. A branch that collides
    // with a load-use stall is dropped here and re-resolves next cycle.
    always_comb begin
        pc_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (w_freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
        end else if (w_lu) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (branch_taken) begin
            IFID_flush  = 1'b1;
        end
    end

    assign mem_timeout = ~rst & (r_timeout | w_timeout_set);

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_cyc;
    assign w_stall_cyc = ~rst & (w_freeze | w_lu);

    hazard_perf_cnt #(
        .PERF_CNT_W (PERF_CNT_W)
    ) u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .i_stall        (w_stall_cyc),
        .i_flush        (IFID_flush),
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
    );
`else
    // Keeps PERF_CNT_W referenced when the counters are compiled out.
    logic w_unused_perf_cfg;
    assign w_unused_perf_cfg = (PERF_CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed vector table, hand-written
// timeout / counter sequences, then randomized traffic against a
// cycle-count reference model.
module tb_hazard_stall_ctrl;

    localparam int REG_ADDR_W   = 5;
    localparam int MAX_MEM_WAIT = 16;
    localparam int PERF_CNT_W   = 32;

    logic                  clk;
    logic                  rst;
    logic                  IDEX_memread;
    logic [REG_ADDR_W-1:0] IDEX_reg_rt;
    logic [REG_ADDR_W-1:0] IFID_reg_rs;
    logic [REG_ADDR_W-1:0] IFID_reg_rt;
    logic                  EXMEM_memread;
    logic                  EXMEM_memwrite;
    logic                  dmem_ready;
    logic                  branch_taken;
    logic                  pc_write;
    logic                  IFID_write;
    logic                  IFID_flush;
    logic                  IDEX_bubble;
    logic                  pipe_freeze;
    logic                  mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cycles;
    logic [PERF_CNT_W-1:0] flush_count;
`endif

    hazard_stall_ctrl #(
        .REG_ADDR_W   (REG_ADDR_W),
        .MAX_MEM_WAIT (MAX_MEM_WAIT),
        .PERF_CNT_W   (PERF_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IDEX_memread   (IDEX_memread),
        .IDEX_reg_rt    (IDEX_reg_rt),
        .IFID_reg_rs    (IFID_reg_rs),
        .IFID_reg_rt    (IFID_reg_rt),
        .EXMEM_memread  (EXMEM_memread),
        .EXMEM_memwrite (EXMEM_memwrite),
        .dmem_ready     (dmem_ready),
        .branch_taken   (branch_taken),
        .pc_write       (pc_write),
        .IFID_write     (IFID_write),
        .IFID_flush     (IFID_flush),
        .IDEX_bubble    (IDEX_bubble),
        .pipe_freeze    (pipe_freeze),
        .mem_timeout    (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks how many consecutive cycles the current memory access has been
    // stalled; everything else follows from the priority rules.
    bit          m_waiting;
    int          m_waited;
    bit          m_to;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    bit e_pc, e_ifw, e_fl, e_bub, e_frz, e_to, e_stall;

    task automatic model_eval();
        bit mem_acc, lu;
        mem_acc = EXMEM_memread || EXMEM_memwrite;
        lu = IDEX_memread && (IDEX_reg_rt != '0) &&
             (IDEX_reg_rt == IFID_reg_rs || IDEX_reg_rt == IFID_reg_rt);
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_frz = 0; e_to = 0; e_stall = 0;
        if (rst) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else begin
            e_frz = !dmem_ready && (m_waiting || mem_acc);
            if (e_frz) begin
                e_pc = 0; e_ifw = 0;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_bub = 1;
            end else if (branch_taken) begin
                e_fl = 1;
            end
            // Stalled-cycle index this cycle is m_waited+1.
            e_to    = m_to || (e_frz && (m_waited + 1 >= MAX_MEM_WAIT));
            e_stall = e_frz || lu;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_waiting = 0; m_waited = 0; m_to = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (e_frz) begin
                m_waiting = 1; m_waited++;
            end else begin
                m_waiting = 0; m_waited = 0;
            end
            m_to = e_to;
            if (e_stall) m_stall = m_stall + 1;
            if (e_fl)    m_flush = m_flush + 1;
        end
    endtask

    task automatic compare_model();
        chk1("m_pc_write",    pc_write,    e_pc);
        chk1("m_IFID_write",  IFID_write,  e_ifw);
        chk1("m_IFID_flush",  IFID_flush,  e_fl);
        chk1("m_IDEX_bubble", IDEX_bubble, e_bub);
        chk1("m_pipe_freeze", pipe_freeze, e_frz);
        chk1("m_mem_timeout", mem_timeout, e_to);
`ifdef HAZARD_PERF_CNT_EN
        chk32("m_stall_cycles", stall_cycles, m_stall);
        chk32("m_flush_count",  flush_count,  m_flush);
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int r, input int idrd, input int idrt, input int ifrs,
                          input int ifrt, input int exrd, input int exwr, input int rdy,
                          input int br);
        rst            = (r != 0);
        IDEX_memread   = (idrd != 0);
        IDEX_reg_rt    = REG_ADDR_W'(idrt);
        IFID_reg_rs    = REG_ADDR_W'(ifrs);
        IFID_reg_rt    = REG_ADDR_W'(ifrt);
        EXMEM_memread  = (exrd != 0);
        EXMEM_memwrite = (exwr != 0);
        dmem_ready     = (rdy != 0);
        branch_taken   = (br != 0);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        int i[9];   // rst idrd idrt ifrs ifrt exrd exwr rdy br
        bit pc, ifw, fl, bub, frz, to;
    } vec_t;

    function automatic vec_t mk(input int r, input int idrd, input int idrt, input int ifrs,
                                input int ifrt, input int exrd, input int exwr, input int rdy,
                                input int br, input bit pc, input bit ifw, input bit fl,
                                input bit bub, input bit frz, input bit to);
        vec_t v;
        v.i = '{r, idrd, idrt, ifrs, ifrt, exrd, exwr, rdy, br};
        v.pc = pc; v.ifw = ifw; v.fl = fl; v.bub = bub; v.frz = frz; v.to = to;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_waiting = 0; m_waited = 0; m_to = 0; m_stall = '0; m_flush = '0;

        //          rst rd rt rs rt2 exr exw rdy br   pc ifw fl bub frz to
        tbl[0]  = mk(1, 0, 0, 0, 0,  0,  0,  1,  0,   0, 0,  0, 1,  0,  0);
        tbl[1]  = mk(1, 0, 0, 0, 0,  0,  0,  1,  0,   0, 0,  0, 1,  0,  0);
        tbl[2]  = mk(0, 0, 0, 0, 0,  0,  0,  1,  0,   1, 1,  0, 0,  0,  0);
        tbl[3]  = mk(0, 1, 5, 5, 0,  0,  0,  1,  0,   0, 0,  0, 1,  0,  0);
        tbl[4]  = mk(0, 0, 5, 5, 0,  0,  0,  1,  0,   1, 1,  0, 0,  0,  0);
        tbl[5]  = mk(0, 1, 7, 1, 7,  0,  0,  1,  0,   0, 0,  0, 1,  0,  0);
        tbl[6]  = mk(0, 1, 0, 0, 0,  0,  0,  1,  0,   1, 1,  0, 0,  0,  0);
        tbl[7]  = mk(0, 0, 0, 0, 0,  0,  0,  1,  1,   1, 1,  1, 0,  0,  0);
        tbl[8]  = mk(0, 1, 3, 3, 0,  0,  0,  1,  1,   0, 0,  0, 1,  0,  0);
        tbl[9]  = mk(0, 0, 3, 3, 0,  0,  0,  1,  1,   1, 1,  1, 0,  0,  0);
        tbl[10] = mk(0, 0, 0, 0, 0,  1,  0,  0,  0,   0, 0,  0, 0,  1,  0);
        tbl[11] = mk(0, 0, 0, 0, 0,  1,  0,  0,  0,   0, 0,  0, 0,  1,  0);
        tbl[12] = mk(0, 0, 0, 0, 0,  1,  0,  0,  0,   0, 0,  0, 0,  1,  0);
        tbl[13] = mk(0, 0, 0, 0, 0,  1,  0,  1,  0,   1, 1,  0, 0,  0,  0);
        tbl[14] = mk(0, 0, 0, 0, 0,  0,  1,  1,  0,   1, 1,  0, 0,  0,  0);
        tbl[15] = mk(0, 1, 2, 2, 0,  0,  1,  0,  1,   0, 0,  0, 0,  1,  0);
        tbl[16] = mk(0, 1, 2, 2, 0,  0,  1,  1,  1,   0, 0,  0, 1,  0,  0);
        tbl[17] = mk(0, 0, 0, 0, 0,  1,  0,  0,  0,   0, 0,  0, 0,  1,  0);
        tbl[18] = mk(1, 0, 0, 0, 0,  1,  0,  0,  0,   0, 0,  0, 1,  0,  0);
        tbl[19] = mk(0, 0, 0, 0, 0,  0,  0,  0,  0,   1, 1,  0, 0,  0,  0);
        tbl[20] = mk(0, 0, 0, 0, 0,  0,  0,  1,  0,   1, 1,  0, 0,  0,  0);

        // Directed vectors
        for (int n = 0; n < 21; n++) begin
            set_in(tbl[n].i[0], tbl[n].i[1], tbl[n].i[2], tbl[n].i[3], tbl[n].i[4],
                   tbl[n].i[5], tbl[n].i[6], tbl[n].i[7], tbl[n].i[8]);
            settle();
            chk1($sformatf("v%0d_pc_write", n),    pc_write,    tbl[n].pc);
            chk1($sformatf("v%0d_IFID_write", n),  IFID_write,  tbl[n].ifw);
            chk1($sformatf("v%0d_IFID_flush", n),  IFID_flush,  tbl[n].fl);
            chk1($sformatf("v%0d_IDEX_bubble", n), IDEX_bubble, tbl[n].bub);
            chk1($sformatf("v%0d_pipe_freeze", n), pipe_freeze, tbl[n].frz);
            chk1($sformatf("v%0d_mem_timeout", n), mem_timeout, tbl[n].to);
            advance();
        end

        // Timeout: flag appears in the 16th stalled cycle, freeze holds,
        // flag survives the completed access and clears only on reset.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); settle(); advance();
        for (int k = 1; k <= 20; k++) begin
            set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
            settle();
            chk1($sformatf("to_freeze_c%0d", k), pipe_freeze, 1'b1);
            chk1($sformatf("to_flag_c%0d", k),   mem_timeout, (k >= MAX_MEM_WAIT));
            advance();
        end
        set_in(0, 0, 0, 0, 0, 1, 0, 1, 0); settle();
        chk1("to_ready_freeze", pipe_freeze, 1'b0);
        chk1("to_ready_pcw",    pc_write,    1'b1);
        chk1("to_ready_flag",   mem_timeout, 1'b1);
        advance();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
            chk1("to_sticky", mem_timeout, 1'b1);
            advance();
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        chk1("to_rst_flag", mem_timeout, 1'b0);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        chk1("to_after_rst", mem_timeout, 1'b0);
        advance();

`ifdef HAZARD_PERF_CNT_EN
        // One load-use stall plus a 3-cycle memory wait, then one flush.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); settle(); advance();
        set_in(0, 1, 5, 5, 0, 0, 0, 1, 0); settle(); advance();
        set_in(0, 0, 5, 5, 0, 0, 0, 1, 0); settle(); advance();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); settle(); advance();
        end
        set_in(0, 0, 0, 0, 0, 1, 0, 1, 0); settle(); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        chk32("pc_stall_cycles", stall_cycles, 32'd4);
        chk32("pc_flush_zero",   flush_count,  32'd0);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); settle(); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); settle();
        chk32("pc_flush_count",  flush_count,  32'd1);
        chk32("pc_stall_hold",   stall_cycles, 32'd4);
        advance();
`endif

        // Randomized traffic against the model
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); settle(); advance();
        for (int c = 0; c < 3000; c++) begin
            bit slow_mem;
            slow_mem = ((c / 60) % 3) == 2;
            rst            = ($urandom_range(0, 63) == 0);
            IDEX_memread   = 1'($urandom_range(0, 1));
            IDEX_reg_rt    = REG_ADDR_W'($urandom_range(0, 3));
            IFID_reg_rs    = REG_ADDR_W'($urandom_range(0, 3));
            IFID_reg_rt    = REG_ADDR_W'($urandom_range(0, 3));
            EXMEM_memread  = ($urandom_range(0, 3) == 0);
            EXMEM_memwrite = ($urandom_range(0, 5) == 0);
            dmem_ready     = slow_mem ? ($urandom_range(0, 24) == 0)
                                      : ($urandom_range(0, 3) != 0);
            branch_taken   = ($urandom_range(0, 4) == 0);
            settle();
            compare_model();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
